// File: rtl/rom_weight_loader.sv
// rom_weight_loader
//
// Walks a contiguous window of the 64x32 weight ROM after a start request
// and streams each word to the kernel/weight buffer. One word is captured
// per accepted beat. A one-cycle done pulse follows the final accepted word.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle burst request, honoured only while idle
//   base_addr  first ROM address of the burst (sampled with start)
//   length     number of words, 0..ROM_DEPTH (sampled with start)
//   rom_addr   registered address to the ROM
//   rom_data   ROM read data, combinational in rom_addr
//   out_data   captured ROM word
//   out_valid  out_data is valid
//   out_ready  downstream accepts the current word
//   out_last   current word is the final word of the burst
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse at burst completion
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_last hold and the word is offered again; out_valid never
// drops without a transfer.
module rom_weight_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ROM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] remaining;
    logic [ADDR_WIDTH:0] start_len;
    logic                fire;
    logic                accept;

    // Requests longer than the ROM are clamped so each word is read at most once.
    assign start_len = (length > MAX_LEN) ? MAX_LEN : length;

    // A new word may be captured when words remain and the output register
    // is either empty or being emptied by a transfer in this same cycle.
    assign fire   = (remaining != '0) && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            rom_addr  <= base_addr;
                            remaining <= start_len;
                            state     <= LOAD;
                        end else begin
                            // Empty burst: straight to completion, no beats.
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (fire) begin
                        // ROM is asynchronous, so rom_data already reflects rom_addr.
                        out_data  <= rom_data;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == ONE);
                        rom_addr  <= rom_addr + 1'b1;  // wraps naturally at the ROM end
                        remaining <= remaining - 1'b1;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // The last word has left; remaining is already zero here.
                    if (accept && out_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rom_weight_loader.md
Name: rom_weight_loader

Overview:
- Sequencer directly upstream of the 64x32 weight ROM (rom_64x32, asynchronous read, a -> spo).
- On a start pulse it walks a contiguous address window of the ROM and captures each word into an output register.
- It streams the captured words to the kernel/weight buffer over a valid/ready handshake with backpressure.
- It raises a one-cycle done pulse after the last word is accepted.

Parameters:
- ADDR_WIDTH, 6, ROM address width.
- DATA_WIDTH, 32, ROM word width.
- ROM_DEPTH, 64, ROM word count; addresses wrap modulo ROM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first ROM address; sampled with start.
- length  in  ADDR_WIDTH+1  word count, 0..ROM_DEPTH; sampled with start.
- rom_addr  out  ADDR_WIDTH  to ROM a; registered.
- rom_data  in  DATA_WIDTH  from ROM spo; combinational function of rom_addr.
- out_data  out  DATA_WIDTH  captured word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  qualifies final word of the burst.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rom_addr=0, remaining=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0.
- Reset mid-burst aborts the burst immediately. No done pulse is issued. Downstream must discard partial data.
- States:
  - IDLE: on start with length!=0, load rom_addr<=base_addr and remaining<=length, then go to LOAD. On start with length==0, go to FIN with no beats. start is ignored in any other state.
  - LOAD: fire = (remaining!=0) && (!out_valid || out_ready). On fire:
    - out_data<=rom_data and out_valid<=1.
    - out_last<=(remaining==1).
    - rom_addr<=rom_addr+1, wrapping 63->0 (natural ADDR_WIDTH overflow).
    - remaining<=remaining-1.
  - LOAD, handshake without fire (out_valid && out_ready && remaining==0): out_valid<=0, out_last<=0.
  - LOAD exit: when out_valid && out_ready && out_last, go to FIN.
  - FIN: done=1 for exactly this one cycle, then IDLE.
- ROM is combinational, so rom_data for rom_addr is captured in the same cycle.
- Latency:
  - start at cycle T, LOAD entered at T+1, first out_valid at T+2.
  - With out_ready held high, one word per cycle with no bubbles.
  - For length=N, last handshake at T+N+1 and done at T+N+2.
- Backpressure: while out_valid && !out_ready, out_data, out_last, rom_addr and remaining hold. No word is skipped or duplicated.
- Back-to-back: start asserted in the FIN cycle is ignored. The next burst may start in the following cycle (IDLE).
- length==ROM_DEPTH (64) reads every word once, ending at base_addr-1 mod 64.
- out_data holds its last value after the burst. Only out_valid qualifies it.
- rom_addr is a registered output, glitch-free to the ROM.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> all outputs 0; release and check state IDLE, busy=0.
- Basic burst: base_addr=0, length=6, out_ready=1 -> out_data = ROM[0..5] in 6 consecutive cycles starting 2 cycles after start; out_last on ROM[5]; done pulses 1 cycle after the last beat; busy high from start+1 through the done cycle.
- Wrap-around: base_addr=62, length=4, out_ready=1 -> words ROM[62], ROM[63], ROM[0], ROM[1]; rom_addr wraps to 0 with no extra cycle.
- Backpressure: base_addr=25, length=5, out_ready toggled 1,0,0,1,0,1... -> exactly ROM[25..29] accepted in order; out_data stable throughout each stall; no duplicates.
- Edge lengths: length=0 -> done 1 cycle after the start cycle with no out_valid; length=64 from base 10 -> 64 words, last is ROM[9].
- Abort and ignore: rst_n=0 mid-burst after 3 beats -> out_valid=0 immediately and no done; start pulsed during LOAD -> ignored and the current burst completes unchanged.
